// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
//   XLEN_DEF / REG_ADDR_W_DEF : default data and register-index widths
//   wb_state_t                : arbitration FSM state
//   wb_req_t                  : one retire request {rd, data} at default widths
package wb_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic {
        WB_NORMAL     = 1'b0,
        WB_FORCE_LOAD = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W_DEF-1:0] rd;
        logic [XLEN_DEF-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Circular-buffer FIFO holding buffered load results.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i, din_i : write request and data (ignored while full)
//   pop_i         : remove head (ignored while empty)
//   head_o        : current head entry
//   count_o       : number of stored entries
//   full_o        : count_o == DEPTH, evaluated before any same-cycle pop
module wb_load_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Full is judged on the pre-pop count, so a pop never frees a slot
    // for a push in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && (count_q != '0);

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage in front of the register file. Arbitrates between the
// single-cycle ALU path and buffered load results, and drives the register
// file write port from registers.
//   clock, reset                     : clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data        : ALU result (held by ALU while !alu_ready)
//   alu_ready                        : ALU result accepted this cycle
//   load_valid/load_rd/load_data     : load result offered
//   load_ready                       : load FIFO can accept
//   reg_write/write_reg/write_data   : registered register-file write port
//   fifo_count                       : loads currently buffered
module writeback_stage
    import wb_pkg::*;
#(
    parameter int XLEN            = XLEN_DEF,
    parameter int REG_ADDR_W      = REG_ADDR_W_DEF,
    parameter int LOAD_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               alu_valid,
    input  logic [REG_ADDR_W-1:0]              alu_rd,
    input  logic [XLEN-1:0]                    alu_data,
    output logic                               alu_ready,
    input  logic                               load_valid,
    input  logic [REG_ADDR_W-1:0]              load_rd,
    input  logic [XLEN-1:0]                    load_data,
    output logic                               load_ready,
    output logic                               reg_write,
    output logic [REG_ADDR_W-1:0]              write_reg,
    output logic [XLEN-1:0]                    write_data,
    output logic [$clog2(LOAD_FIFO_DEPTH):0]   fifo_count
);

    localparam int REQ_W  = REG_ADDR_W + XLEN;
    localparam int CNT_W  = $clog2(LOAD_FIFO_DEPTH) + 1;
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    wb_state_t             state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  reg_write_q;
    logic [REG_ADDR_W-1:0] write_reg_q;
    logic [XLEN-1:0]       write_data_q;

    logic [REQ_W-1:0]      head;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;
    logic [CNT_W-1:0]      count;
    logic                  fifo_full, fifo_empty;
    logic                  pop;
    logic                  ret_vld;
    logic [REG_ADDR_W-1:0] ret_rd;
    logic [XLEN-1:0]       ret_data;

    wb_load_fifo #(
        .DEPTH (LOAD_FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_load_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (load_valid),
        .din_i   ({load_rd, load_data}),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count),
        .full_o  (fifo_full)
    );

    assign head_rd    = head[REQ_W-1:XLEN];
    assign head_data  = head[XLEN-1:0];
    assign fifo_empty = (count == '0);

    // alu_ready depends on registered state only, never on alu_valid.
    assign alu_ready  = (state_q == WB_NORMAL);
    assign load_ready = !fifo_full;
    assign fifo_count = count;

    assign reg_write  = reg_write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        pop      = 1'b0;
        ret_vld  = 1'b0;
        ret_rd   = alu_rd;
        ret_data = alu_data;
        case (state_q)
            WB_NORMAL: begin
                if (alu_valid) begin
                    ret_vld = 1'b1;
                    // ALU beat a waiting load: count toward a forced load slot.
                    if (!fifo_empty) begin
                        wait_d = wait_q + WAIT_W'(1);
                        if (wait_q == WAIT_W'(STARVE_LIMIT - 1)) state_d = WB_FORCE_LOAD;
                    end
                end else if (!fifo_empty) begin
                    pop      = 1'b1;
                    ret_vld  = 1'b1;
                    ret_rd   = head_rd;
                    ret_data = head_data;
                end
            end
            WB_FORCE_LOAD: begin
                // No pop happened since entry, so the head is present.
                pop      = 1'b1;
                ret_vld  = 1'b1;
                ret_rd   = head_rd;
                ret_data = head_data;
                state_d  = WB_NORMAL;
            end
            default: state_d = WB_NORMAL;
        endcase
        if (pop || fifo_empty) wait_d = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= WB_NORMAL;
            wait_q       <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            // x0 requests are consumed but never written.
            reg_write_q <= ret_vld && (ret_rd != '0);
            if (ret_vld) begin
                write_reg_q  <= ret_rd;
                write_data_q <= ret_data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
    import wb_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        load_valid = 1'b0;
    logic [4:0]  load_rd = '0;
    logic [31:0] load_data = '0;
    logic        load_ready;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [1:0]  fifo_count;

    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    // Reference model state
    wb_req_t lq[$];   // buffered loads, in arrival order
    wb_req_t sb[$];   // expected register-file writes
    int      m_wait  = 0;
    bit      m_force = 1'b0;
    bit      last_alu_acc;
    bit      last_load_acc;

    writeback_stage #(
        .XLEN            (32),
        .REG_ADDR_W      (5),
        .LOAD_FIFO_DEPTH (DEPTH),
        .STARVE_LIMIT    (LIMIT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .load_valid (load_valid),
        .load_rd    (load_rd),
        .load_data  (load_data),
        .load_ready (load_ready),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock cycle: drive inputs, check handshake outputs against the model,
    // advance the model, then let the edge happen.
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        bit      e_alu_rdy, e_load_rdy, have;
        int      pre;
        wb_req_t r;
        @(negedge clock);
        #1;
        alu_valid  = av;
        alu_rd     = ard;
        alu_data   = ad;
        load_valid = lv;
        load_rd    = lrd;
        load_data  = ld;
        e_alu_rdy  = !m_force;
        e_load_rdy = (lq.size() < DEPTH);
        chk("alu_ready", 64'(alu_ready), 64'(e_alu_rdy));
        chk("load_ready", 64'(load_ready), 64'(e_load_rdy));
        chk("fifo_count", 64'(fifo_count), 64'(lq.size()));
        have = 1'b0;
        r    = '0;
        pre  = lq.size();
        if (m_force) begin
            if (pre > 0) begin
                r    = lq.pop_front();
                have = 1'b1;
            end
            m_force = 1'b0;
            m_wait  = 0;
        end else if (av) begin
            r.rd   = ard;
            r.data = ad;
            have   = 1'b1;
            if (pre > 0) begin
                m_wait++;
                if (m_wait == LIMIT) m_force = 1'b1;
            end else begin
                m_wait = 0;
            end
        end else if (pre > 0) begin
            r      = lq.pop_front();
            have   = 1'b1;
            m_wait = 0;
        end else begin
            m_wait = 0;
        end
        last_alu_acc  = av && e_alu_rdy;
        last_load_acc = lv && e_load_rdy;
        if (last_load_acc) begin
            wb_req_t n;
            n.rd   = lrd;
            n.data = ld;
            lq.push_back(n);
        end
        if (have && r.rd != 5'd0) sb.push_back(r);
        @(posedge clock);
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        alu_valid  = 1'b0;
        load_valid = 1'b0;
        reset      = 1'b0;
        lq.delete();
        sb.delete();
        m_wait  = 0;
        m_force = 1'b0;
        #1;
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("rst_reg_write", 64'(reg_write), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);
        chk("rst_load_ready", 64'(load_ready), 64'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        #2;
        reset = 1'b1;
    endtask

    // Monitor: every negedge, a write is expected exactly when the scoreboard holds one.
    initial begin : monitor
        wb_req_t e;
        bit      exp_wr;
        forever begin
            @(negedge clock);
            if (done) break;
            exp_wr = (sb.size() != 0);
            chk("mon_reg_write", 64'(reg_write), 64'(exp_wr));
            if (exp_wr) begin
                e = sb.pop_front();
                chk("mon_write_reg", 64'(write_reg), 64'(e.rd));
                chk("mon_write_data", 64'(write_data), 64'(e.data));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit          av, lv, pend_a, pend_l;
        logic [4:0]  ard, lrd;
        logic [31:0] ad, ld;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("init_reg_write", 64'(reg_write), 64'd0);
        chk("init_write_reg", 64'(write_reg), 64'd0);
        chk("init_write_data", 64'(write_data), 64'd0);
        chk("init_fifo_count", 64'(fifo_count), 64'd0);
        chk("init_alu_ready", 64'(alu_ready), 64'd1);
        chk("init_load_ready", 64'(load_ready), 64'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        #2 reset = 1'b1;

        // Single ALU write, visible for exactly one cycle
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        #1;
        chk("alu_we", 64'(reg_write), 64'd1);
        chk("alu_rd", 64'(write_reg), 64'd5);
        chk("alu_data", 64'(write_data), 64'hDEADBEEF);
        idle();
        #1;
        chk("alu_we_drop", 64'(reg_write), 64'd0);
        chk("alu_rd_hold", 64'(write_reg), 64'd5);
        chk("alu_data_hold", 64'(write_data), 64'hDEADBEEF);

        // x0 suppression on both paths
        cycle(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h55);
        #1 chk("x0_alu_we", 64'(reg_write), 64'd0);
        idle();
        #1;
        chk("x0_load_we", 64'(reg_write), 64'd0);
        chk("x0_fifo_empty", 64'(fifo_count), 64'd0);

        // FIFO full while the ALU is busy; third load held until room appears
        cycle(1'b1, 5'd20, 32'hA0, 1'b1, 5'd1, 32'h11);
        cycle(1'b1, 5'd21, 32'hA1, 1'b1, 5'd2, 32'h22);
        #1;
        chk("full_count", 64'(fifo_count), 64'd2);
        chk("full_load_ready", 64'(load_ready), 64'd0);
        cycle(1'b1, 5'd22, 32'hA2, 1'b1, 5'd3, 32'h33);
        cycle(1'b1, 5'd23, 32'hA3, 1'b1, 5'd3, 32'h33);
        cycle(1'b1, 5'd24, 32'hA4, 1'b1, 5'd3, 32'h33);
        cycle(1'b1, 5'd25, 32'hA5, 1'b1, 5'd3, 32'h33);
        #1 chk("full_forced_rd", 64'(write_reg), 64'd1);
        cycle(1'b1, 5'd25, 32'hA5, 1'b1, 5'd3, 32'h33);
        repeat (4) idle();

        // Starvation: ALU every cycle with one load (rd 7) waiting
        cycle(1'b1, 5'd10, 32'hB0, 1'b1, 5'd7, 32'h77);
        for (int i = 0; i < 4; i++) cycle(1'b1, 5'(11 + i), 32'(32'hB1 + i), 1'b0, 5'd0, 32'd0);
        #1 chk("starve_alu_ready_low", 64'(alu_ready), 64'd0);
        cycle(1'b1, 5'd15, 32'hB5, 1'b0, 5'd0, 32'd0);
        #1;
        chk("starve_load_rd", 64'(write_reg), 64'd7);
        chk("starve_load_data", 64'(write_data), 64'h77);
        chk("starve_alu_ready_back", 64'(alu_ready), 64'd1);
        cycle(1'b1, 5'd15, 32'hB5, 1'b0, 5'd0, 32'd0);
        #1 chk("starve_resume_rd", 64'(write_reg), 64'd15);
        idle();

        // Simultaneous push and pop with one entry buffered
        cycle(1'b1, 5'd16, 32'hC0, 1'b1, 5'd8, 32'h88);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
        #1;
        chk("pp_count", 64'(fifo_count), 64'd1);
        chk("pp_first_rd", 64'(write_reg), 64'd8);
        idle();
        #1;
        chk("pp_second_rd", 64'(write_reg), 64'd9);
        chk("pp_empty", 64'(fifo_count), 64'd0);

        // Ten loads in a row, retire order follows push order
        for (int i = 0; i < 10; i++) cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 1), $urandom);
        repeat (2) idle();

        // Reset with two loads buffered: they must never be written
        cycle(1'b1, 5'd26, 32'hD0, 1'b1, 5'd3, 32'hE3);
        cycle(1'b1, 5'd27, 32'hD1, 1'b1, 5'd4, 32'hE4);
        #1 chk("pre_rst_count", 64'(fifo_count), 64'd2);
        do_reset();
        repeat (3) idle();

        // Randomized traffic, producers hold unaccepted results
        pend_a = 1'b0;
        pend_l = 1'b0;
        av = 1'b0; lv = 1'b0; ard = '0; lrd = '0; ad = '0; ld = '0;
        for (int i = 0; i < 500; i++) begin
            if (!pend_a) begin
                av  = ($urandom_range(0, 9) < 6);
                ard = 5'($urandom_range(0, 31));
                ad  = $urandom;
            end
            if (!pend_l) begin
                lv  = ($urandom_range(0, 9) < 5);
                lrd = 5'($urandom_range(0, 31));
                ld  = $urandom;
            end
            cycle(av, ard, ad, lv, lrd, ld);
            pend_a = av && !last_alu_acc;
            pend_l = lv && !last_load_acc;
        end
        for (int i = 0; i < 12 && (pend_a || pend_l); i++) begin
            cycle(pend_a, ard, ad, pend_l, lrd, ld);
            pend_a = pend_a && !last_alu_acc;
            pend_l = pend_l && !last_load_acc;
        end
        repeat (6) idle();
        @(negedge clock);
        #2;
        chk("end_model_empty", 64'(lq.size()), 64'd0);
        chk("end_scoreboard_empty", 64'(sb.size()), 64'd0);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage in front of `reg_file`: it collects results from the single-cycle ALU path and the variable-latency load path, arbitrates between them, and drives the register file's `reg_write`/`write_reg`/`write_data` inputs from registers. Load results are buffered in a small FIFO. A starvation counter guarantees that loads are not blocked forever by back-to-back ALU results. Writes targeting x0 are consumed but never reach the register file.

## Interface
- `XLEN`, 32, data width
- `REG_ADDR_W`, 5, register index width
- `LOAD_FIFO_DEPTH`, 2, load-result buffer entries (power of two, ≥2)
- `STARVE_LIMIT`, 4, consecutive blocked cycles before a load is forced
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU result present this cycle
- `alu_rd`  in  REG_ADDR_W  ALU destination register
- `alu_data`  in  XLEN  ALU result
- `alu_ready`  out  1  ALU result accepted this cycle; the ALU must hold its result when this is low
- `load_valid`  in  1  load result offered
- `load_rd`  in  REG_ADDR_W  load destination register
- `load_data`  in  XLEN  load result
- `load_ready`  out  1  FIFO can accept a load result
- `reg_write`  out  1  to `reg_file.reg_write`
- `write_reg`  out  REG_ADDR_W  to `reg_file.write_reg`
- `write_data`  out  XLEN  to `reg_file.write_data`
- `fifo_count`  out  $clog2(LOAD_FIFO_DEPTH)+1  loads currently buffered (debug/verification)

## Operation
- **Load FIFO**
  - Push on `load_valid && load_ready`.
  - `load_ready = (fifo_count != LOAD_FIFO_DEPTH)`. Full status is evaluated before the same-cycle pop, so a pop does not make room in the same cycle.
  - Simultaneous push and pop when not full: count is unchanged and order is preserved.
  - A push attempted while full is ignored; the producer holds its result.
- **FSM states**
  - `WB_NORMAL`:
    - `alu_ready = 1`.
    - If `alu_valid`, the ALU result retires.
    - Otherwise, if the FIFO is non-empty, the head retires.
    - When the FIFO is non-empty and the ALU wins, `wait_cnt` increments.
    - If `wait_cnt` reaches `STARVE_LIMIT` on this increment, the next state is `WB_FORCE_LOAD`.
  - `WB_FORCE_LOAD`:
    - `alu_ready = 0`.
    - The FIFO head retires; this is guaranteed non-empty because no pop occurred since entry.
    - Next state is `WB_NORMAL`.
  - `wait_cnt` clears to 0 on any FIFO pop and whenever the FIFO is empty.
  - `alu_ready` is decoded from registered state only and has no combinational path from `alu_valid`.
- **Retire**
  - The retired request `{rd, data}` is registered into `write_reg`/`write_data`.
  - `reg_write <= (rd != 0)`.
  - Cycles with no retire leave `reg_write = 0`; `write_reg`/`write_data` hold their last values.
  - An x0 request is still consumed: it pops the FIFO or completes the ALU handshake.
- **Reset**
  - `reg_write = 0`, `write_reg = 0`, `write_data = 0`.
  - FIFO empty, `fifo_count = 0`, `wait_cnt = 0`, state `WB_NORMAL`.
  - Therefore `alu_ready = 1` and `load_ready = 1` during and after reset.
- **Reset mid-operation:** buffered loads are discarded. Replaying them is the upstream stage's responsibility.

## Timing
- Latency, ALU path: result accepted at edge N → `reg_write` high after edge N → `reg_file` updated at edge N+1.
- Latency, load path: minimum is push at edge N → outputs valid after edge N+1, since a pushed entry is not poppable in its push cycle.
- `wait_cnt` sequence: the count reaches `STARVE_LIMIT` after that many consecutive blocked ALU-win cycles. `alu_ready` is low for exactly one cycle, the following one.
- `reset` deassertion is synchronized by the top level; this block only uses async assert.

## Structure
- `wb_pkg`:
  - `XLEN_DEF`, `REG_ADDR_W_DEF`
  - `typedef enum logic {WB_NORMAL, WB_FORCE_LOAD} wb_state_t`
  - `typedef struct packed {logic [REG_ADDR_W-1:0] rd; logic [XLEN-1:0] data;} wb_req_t`
- Sub-module `wb_load_fifo`:
  - Parameterized synchronous FIFO of `wb_req_t` with push, pop, head, count, and full outputs.
  - Storage is a circular buffer with wrap-around read/write pointers.
- Top level contains the FSM, `wait_cnt`, the arbitration mux, and the output registers.

## Test plan
- **Reset:** assert `reset` low mid-traffic with 2 loads buffered → `fifo_count = 0`, `reg_write = 0`, `alu_ready = 1`, `load_ready = 1`; no buffered load is ever written.
- **Single ALU write:** ALU `rd=5`, `data=0xDEADBEEF` at edge N → `reg_write = 1`, `write_reg = 5`, `write_data = 0xDEADBEEF` for exactly one cycle after N.
- **x0 suppression:** ALU `rd=0`, `data=0x1234`; load `rd=0` → `reg_write` stays 0; `fifo_count` returns to 0.
- **FIFO full / wrap-around:**
  - Push 2 loads (rd 1, 2) while ALU is busy → `load_ready = 0`, and a third push is ignored until a pop.
  - Across 10 loads, the retire order matches the push order.
- **Starvation:** ALU valid every cycle with 1 load buffered (`rd=7`) → after 4 ALU retires, `alu_ready = 0` for one cycle, then `write_reg = 7` retires, then ALU traffic resumes.
- **Simultaneous push/pop:** with `fifo_count = 1`, push and pop in the same cycle while ALU is idle → `fifo_count` stays 1 and data order is correct.
